// File: rtl/stopwatch_input_ctrl.sv
// ---------------------------------------------------------------------------
// stopwatch_input_ctrl
//
// Input-side front end for the stopwatch counter. It takes the raw board
// buttons and switches and produces clean, single-clock-domain controls.
// It also derives the slow timing ticks and square waves from the board
// clock.
//
// Signal path for each raw input:
//   2-flop synchronizer -> debouncer (state + stability counter)
//   -> press detector (buttons only: registered rising edge)
//
// Optional build macro:
//   ADJ_TICK_GATE_EN - when defined, clk_1hz is suppressed while adj is high.
//                      Divider c1 keeps running, so the tick phase is kept.
//
// Parameters:
//   CLK_HZ          board clock frequency in Hz (divisible by 8)
//   FST_HZ          display scan square-wave frequency
//   DEBOUNCE_CYCLES consecutive stable cycles needed to accept a new level
//
// Ports:
//   clk        in   board clock, sole clock domain
//   rst        in   synchronous, active-high reset
//   btn_pause  in   raw pause pushbutton (asynchronous, active-high)
//   btn_reset  in   raw reset pushbutton (asynchronous, active-high)
//   sw_select  in   raw select switch (asynchronous)
//   sw_adj     in   raw adjust switch (asynchronous)
//   pause_d    out  pause level, toggles on each accepted pause press
//   rst_d      out  one-cycle pulse per accepted reset press
//   select     out  debounced sw_select level
//   adj        out  debounced sw_adj level
//   clk_1hz    out  one-cycle enable pulse at 1 Hz
//   clk_2hz    out  one-cycle enable pulse at 2 Hz
//   clk_4hz    out  50% duty square wave at 4 Hz (blink level)
//   clk_fst    out  50% duty square wave at FST_HZ (display scan)
// ---------------------------------------------------------------------------
module stopwatch_input_ctrl #(
    parameter int CLK_HZ          = 100000000,
    parameter int FST_HZ          = 500,
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_pause,
    input  logic btn_reset,
    input  logic sw_select,
    input  logic sw_adj,
    output logic pause_d,
    output logic rst_d,
    output logic select,
    output logic adj,
    output logic clk_1hz,
    output logic clk_2hz,
    output logic clk_4hz,
    output logic clk_fst
);

    // -----------------------------------------------------------------------
    // Local constants
    // -----------------------------------------------------------------------
    // Bit positions of the four conditioned inputs in the packed vectors.
    localparam int IDX_PAUSE  = 0;
    localparam int IDX_RESET  = 1;
    localparam int IDX_SELECT = 2;
    localparam int IDX_ADJ    = 3;
    localparam int N_IN       = 4;

    localparam int                DB_W    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [DB_W-1:0]   DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    // Terminal counts of the dividers. Each width is sized to hold its
    // terminal count and is kept at least 1 bit wide so that degenerate
    // parameter choices (terminal count of 0) still elaborate.
    localparam int C1_MAX = CLK_HZ - 1;
    localparam int C2_MAX = CLK_HZ / 2 - 1;
    localparam int C4_MAX = CLK_HZ / 8 - 1;
    localparam int CF_MAX = CLK_HZ / (2 * FST_HZ) - 1;

    localparam int C1_W = (C1_MAX < 1) ? 1 : $clog2(C1_MAX + 1);
    localparam int C2_W = (C2_MAX < 1) ? 1 : $clog2(C2_MAX + 1);
    localparam int C4_W = (C4_MAX < 1) ? 1 : $clog2(C4_MAX + 1);
    localparam int CF_W = (CF_MAX < 1) ? 1 : $clog2(CF_MAX + 1);

    localparam logic [C1_W-1:0] C1_LAST = C1_W'(C1_MAX);
    localparam logic [C2_W-1:0] C2_LAST = C2_W'(C2_MAX);
    localparam logic [C4_W-1:0] C4_LAST = C4_W'(C4_MAX);
    localparam logic [CF_W-1:0] CF_LAST = CF_W'(CF_MAX);

    // -----------------------------------------------------------------------
    // Signals
    // -----------------------------------------------------------------------
    logic [N_IN-1:0] raw;
    logic [N_IN-1:0] sync_p0;      // first synchronizer flop (may be metastable)
    logic [N_IN-1:0] sync_p1;      // second synchronizer flop (safe to use)
    logic [N_IN-1:0] deb_state;    // accepted (debounced) levels
    logic [DB_W-1:0] deb_cnt [N_IN];

    logic [1:0]      btn_prev;     // previous debounced button levels
    logic            press_pause;
    logic            press_reset;

    logic [C1_W-1:0] c1;
    logic [C2_W-1:0] c2;
    logic [C4_W-1:0] c4;
    logic [CF_W-1:0] cf;
    logic            tick_1hz_next;

    assign raw = {sw_adj, sw_select, btn_reset, btn_pause};

    // -----------------------------------------------------------------------
    // Stage p0/p1: two-flop synchronizers for all raw inputs
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_p0 <= '0;
            sync_p1 <= '0;
        end else begin
            sync_p0 <= raw;
            sync_p1 <= sync_p0;
        end
    end

    // -----------------------------------------------------------------------
    // Debounce: each input must disagree with its accepted state for
    // DEBOUNCE_CYCLES consecutive cycles before the new level is taken.
    // Any return to the accepted level restarts the count from zero.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            deb_state <= '0;
            for (int i = 0; i < N_IN; i++) begin
                deb_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_IN; i++) begin
                if (sync_p1[i] == deb_state[i]) begin
                    deb_cnt[i] <= '0;
                end else if (deb_cnt[i] == DB_LAST) begin
                    deb_state[i] <= sync_p1[i];
                    deb_cnt[i]   <= '0;
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign select = deb_state[IDX_SELECT];
    assign adj    = deb_state[IDX_ADJ];

    // -----------------------------------------------------------------------
    // Press detection: rising edge of the debounced button levels, applied
    // to the registered pause/reset outputs one cycle after acceptance.
    // -----------------------------------------------------------------------
    assign press_pause = deb_state[IDX_PAUSE] & ~btn_prev[0];
    assign press_reset = deb_state[IDX_RESET] & ~btn_prev[1];

    always_ff @(posedge clk) begin
        if (rst) begin
            btn_prev <= '0;
            rst_d    <= 1'b0;
            pause_d  <= 1'b0;
        end else begin
            btn_prev <= {deb_state[IDX_RESET], deb_state[IDX_PAUSE]};
            rst_d    <= press_reset;
            // A reset press takes priority over a simultaneous pause press.
            if (press_reset) begin
                pause_d <= 1'b0;
            end else if (press_pause) begin
                pause_d <= ~pause_d;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Tick dividers: free-running, cleared only by rst. c1 and c2 start
    // together so every 1 Hz pulse lines up with a 2 Hz pulse.
    // -----------------------------------------------------------------------
`ifdef ADJ_TICK_GATE_EN
    // The counter stays frozen during adjust because its tick is masked here;
    // c1 itself never stops, so the next pulse after adjust lands on the
    // normal 1 s boundary.
    assign tick_1hz_next = (c1 == C1_LAST) && !deb_state[IDX_ADJ];
`else
    assign tick_1hz_next = (c1 == C1_LAST);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            c1      <= '0;
            c2      <= '0;
            clk_1hz <= 1'b0;
            clk_2hz <= 1'b0;
        end else begin
            clk_1hz <= tick_1hz_next;
            clk_2hz <= (c2 == C2_LAST);
            c1      <= (c1 == C1_LAST) ? '0 : c1 + 1'b1;
            c2      <= (c2 == C2_LAST) ? '0 : c2 + 1'b1;
        end
    end

    // Square waves: toggle on each terminal count, giving 50% duty.
    always_ff @(posedge clk) begin
        if (rst) begin
            c4      <= '0;
            cf      <= '0;
            clk_4hz <= 1'b0;
            clk_fst <= 1'b0;
        end else begin
            if (c4 == C4_LAST) begin
                c4      <= '0;
                clk_4hz <= ~clk_4hz;
            end else begin
                c4 <= c4 + 1'b1;
            end
            if (cf == CF_LAST) begin
                cf      <= '0;
                clk_fst <= ~clk_fst;
            end else begin
                cf <= cf + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_stopwatch_input_ctrl.sv
// ---------------------------------------------------------------------------
// tb_stopwatch_input_ctrl
//
// Scoreboard bench for stopwatch_input_ctrl with CLK_HZ=80, FST_HZ=20,
// DEBOUNCE_CYCLES=4. The stimulus process pushes the expected output events
// (cycle number and value) into per-signal queues; a monitor samples the DUT
// on the falling edge and pops/compares whenever an output pulses or changes.
// Cycle k means "after the k-th rising edge with rst low".
// Build with +define+ADJ_TICK_GATE_EN to check the gated 1 Hz tick variant.
// ---------------------------------------------------------------------------
module tb_stopwatch_input_ctrl;

    localparam int CLK_HZ = 80;
    localparam int FST_HZ = 20;
    localparam int DEB    = 4;

    logic clk       = 1'b0;
    logic rst       = 1'b1;
    logic btn_pause = 1'b0;
    logic btn_reset = 1'b0;
    logic sw_select = 1'b0;
    logic sw_adj    = 1'b0;
    logic pause_d, rst_d, select, adj;
    logic clk_1hz, clk_2hz, clk_4hz, clk_fst;

    stopwatch_input_ctrl #(
        .CLK_HZ         (CLK_HZ),
        .FST_HZ         (FST_HZ),
        .DEBOUNCE_CYCLES(DEB)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .btn_pause(btn_pause),
        .btn_reset(btn_reset),
        .sw_select(sw_select),
        .sw_adj   (sw_adj),
        .pause_d  (pause_d),
        .rst_d    (rst_d),
        .select   (select),
        .adj      (adj),
        .clk_1hz  (clk_1hz),
        .clk_2hz  (clk_2hz),
        .clk_4hz  (clk_4hz),
        .clk_fst  (clk_fst)
    );

    always #5 clk = ~clk;

    typedef struct {
        int cyc;
        bit val;
    } ev_t;

    int  q_rst[$];
    int  q_1hz[$];
    int  q_2hz[$];
    int  q_4hz[$];
    int  q_fst[$];
    ev_t q_pause[$];
    ev_t q_adj[$];
    ev_t q_sel[$];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    bit armed    = 1'b0;
    bit mon_tick = 1'b0;
    bit mon_sq   = 1'b0;

    function automatic void chk(string name, int act, int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Cycle counter, restarted by reset.
    initial begin
        forever begin
            @(posedge clk);
            if (rst) cyc = 0;
            else     cyc = cyc + 1;
        end
    end

    // Monitor: pops an expectation whenever the DUT presents an event.
    initial begin
        logic pp, pa, ps, p4, pf;
        ev_t  e;
        int   c;
        pp = 1'b0; pa = 1'b0; ps = 1'b0; p4 = 1'b0; pf = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst && armed) begin
                if (rst_d === 1'b1) begin
                    if (q_rst.size() == 0) chk("rst_d unexpected pulse", cyc, -1);
                    else begin c = q_rst.pop_front(); chk("rst_d pulse cycle", cyc, c); end
                end
                if (mon_tick && clk_1hz === 1'b1) begin
                    if (q_1hz.size() == 0) chk("clk_1hz unexpected pulse", cyc, -1);
                    else begin c = q_1hz.pop_front(); chk("clk_1hz pulse cycle", cyc, c); end
                end
                if (mon_tick && clk_2hz === 1'b1) begin
                    if (q_2hz.size() == 0) chk("clk_2hz unexpected pulse", cyc, -1);
                    else begin c = q_2hz.pop_front(); chk("clk_2hz pulse cycle", cyc, c); end
                end
                if (mon_sq && clk_4hz !== p4) begin
                    if (q_4hz.size() == 0) chk("clk_4hz unexpected toggle", cyc, -1);
                    else begin c = q_4hz.pop_front(); chk("clk_4hz toggle cycle", cyc, c); end
                end
                if (mon_sq && clk_fst !== pf) begin
                    if (q_fst.size() == 0) chk("clk_fst unexpected toggle", cyc, -1);
                    else begin c = q_fst.pop_front(); chk("clk_fst toggle cycle", cyc, c); end
                end
                if (pause_d !== pp) begin
                    if (q_pause.size() == 0) chk("pause_d unexpected change", cyc, -1);
                    else begin
                        e = q_pause.pop_front();
                        chk("pause_d change cycle", cyc, e.cyc);
                        chk("pause_d value", int'(pause_d), int'(e.val));
                    end
                end
                if (adj !== pa) begin
                    if (q_adj.size() == 0) chk("adj unexpected change", cyc, -1);
                    else begin
                        e = q_adj.pop_front();
                        chk("adj change cycle", cyc, e.cyc);
                        chk("adj value", int'(adj), int'(e.val));
                    end
                end
                if (select !== ps) begin
                    if (q_sel.size() == 0) chk("select unexpected change", cyc, -1);
                    else begin
                        e = q_sel.pop_front();
                        chk("select change cycle", cyc, e.cyc);
                        chk("select value", int'(select), int'(e.val));
                    end
                end
            end
            pp = pause_d; pa = adj; ps = select; p4 = clk_4hz; pf = clk_fst;
        end
    end

    // Watchdog so the bench can never hang.
    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, tests=%0d", n_tests);
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic steps(input int n);
        repeat (n) step();
    endtask

    task automatic run_to(input int n);
        while (cyc < n) step();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        steps(3);
        chk("reset pause_d", int'(pause_d), 0);
        chk("reset rst_d",   int'(rst_d),   0);
        chk("reset select",  int'(select),  0);
        chk("reset adj",     int'(adj),     0);
        chk("reset clk_1hz", int'(clk_1hz), 0);
        chk("reset clk_2hz", int'(clk_2hz), 0);
        chk("reset clk_4hz", int'(clk_4hz), 0);
        chk("reset clk_fst", int'(clk_fst), 0);
        rst = 1'b0;
    endtask

    initial begin
        int k;
        bit v;
        bit pat[5];
        pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b1; pat[3] = 1'b1; pat[4] = 1'b0;

        // Scenario 1: idle tick timing from reset.
        do_reset();
        armed = 1'b1; mon_tick = 1'b1; mon_sq = 1'b1;
        for (int i = 1; i <= 2;  i++) q_1hz.push_back(80 * i);
        for (int i = 1; i <= 4;  i++) q_2hz.push_back(40 * i);
        for (int i = 1; i <= 16; i++) q_4hz.push_back(10 * i);
        for (int i = 1; i <= 80; i++) q_fst.push_back(2 * i);
        run_to(161);
        mon_tick = 1'b0; mon_sq = 1'b0;

        // Scenario 2: held reset button gives a single rst_d pulse.
        k = cyc;
        btn_reset = 1'b1;
        q_rst.push_back(k + 7);
        steps(20);
        btn_reset = 1'b0;
        steps(20);

        // Scenario 3: three pause presses toggle pause_d 1, 0, 1.
        v = 1'b0;
        for (int i = 0; i < 3; i++) begin
            k = cyc;
            v = ~v;
            btn_pause = 1'b1;
            q_pause.push_back('{k + 7, v});
            steps(10);
            btn_pause = 1'b0;
            steps(10);
        end

        // Scenario 5: simultaneous presses with pause_d=1, reset wins.
        k = cyc;
        btn_pause = 1'b1; btn_reset = 1'b1;
        q_rst.push_back(k + 7);
        q_pause.push_back('{k + 7, 1'b0});
        steps(10);
        btn_pause = 1'b0; btn_reset = 1'b0;
        steps(10);

        // Simultaneous presses with pause_d=0: pause_d must stay 0.
        k = cyc;
        btn_pause = 1'b1; btn_reset = 1'b1;
        q_rst.push_back(k + 7);
        steps(10);
        btn_pause = 1'b0; btn_reset = 1'b0;
        steps(10);

        // Scenario 4: bouncing adj switch is rejected, stable level accepted.
        for (int r = 0; r < 4; r++) begin
            for (int j = 0; j < 5; j++) begin
                sw_adj = pat[j];
                step();
            end
        end
        k = cyc;
        sw_adj = 1'b1;
        q_adj.push_back('{k + 6, 1'b1});
        steps(10);
        k = cyc;
        sw_select = 1'b1;
        q_sel.push_back('{k + 6, 1'b1});
        steps(10);
        k = cyc;
        sw_adj = 1'b0; sw_select = 1'b0;
        q_adj.push_back('{k + 6, 1'b0});
        q_sel.push_back('{k + 6, 1'b0});
        steps(10);

        // Scenario 6: adj high across the 1 s boundary at cycle 80.
        do_reset();
        mon_tick = 1'b1;
        for (int i = 1; i <= 4; i++) q_2hz.push_back(40 * i);
`ifdef ADJ_TICK_GATE_EN
        q_1hz.push_back(160);
`else
        q_1hz.push_back(80);
        q_1hz.push_back(160);
`endif
        run_to(64);
        sw_adj = 1'b1;
        q_adj.push_back('{70, 1'b1});
        run_to(94);
        sw_adj = 1'b0;
        q_adj.push_back('{100, 1'b0});
        run_to(161);
        mon_tick = 1'b0;
        steps(2);

        // Every expected event must have been consumed.
        chk("rst_d events left",   q_rst.size(),   0);
        chk("clk_1hz events left", q_1hz.size(),   0);
        chk("clk_2hz events left", q_2hz.size(),   0);
        chk("clk_4hz events left", q_4hz.size(),   0);
        chk("clk_fst events left", q_fst.size(),   0);
        chk("pause_d events left", q_pause.size(), 0);
        chk("adj events left",     q_adj.size(),   0);
        chk("select events left",  q_sel.size(),   0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/stopwatch_input_ctrl.md
Name: stopwatch_input_ctrl

Overview:
Input-side front end for the stopwatch counter. It conditions the raw board buttons and switches into the debounced, edge-qualified controls the counter consumes: pause_d, rst_d, select, adj. It also generates the clk_1hz, clk_2hz, clk_4hz and clk_fst timing signals from the single board clock.

Parameters:
CLK_HZ, 100000000, board clock frequency in Hz; must be divisible by 8.
FST_HZ, 500, display scan square-wave frequency; CLK_HZ/(2*FST_HZ) must be an integer >= 1.
DEBOUNCE_CYCLES, 1000000, consecutive stable cycles required to accept a new button/switch level; >= 2.

Ports:
clk  input  1  board clock; sole clock domain.
rst  input  1  synchronous, active-high reset.
btn_pause  input  1  raw pause pushbutton, asynchronous, active-high.
btn_reset  input  1  raw reset pushbutton, asynchronous, active-high.
sw_select  input  1  raw select switch, asynchronous.
sw_adj  input  1  raw adjust switch, asynchronous.
pause_d  output  1  pause state level; toggles on each accepted pause press.
rst_d  output  1  one-cycle pulse per accepted reset press.
select  output  1  debounced sw_select level.
adj  output  1  debounced sw_adj level.
clk_1hz  output  1  one-cycle enable pulse at 1 Hz.
clk_2hz  output  1  one-cycle enable pulse at 2 Hz.
clk_4hz  output  1  50% duty square wave at 4 Hz; blink level.
clk_fst  output  1  50% duty square wave at FST_HZ; display scan.

Behaviour:
- Clock and reset: one clock, clk. Reset is rst: synchronous and active-high.
- Reset: all outputs 0. All synchronizer flops, debounced states, debounce counters, edge registers and divider counters are 0. Reset mid-debounce discards progress.
- Sync: each raw input passes through a 2-flop synchronizer.
- Debounce, per input, independent:
  - state register plus a counter of width $clog2(DEBOUNCE_CYCLES).
  - synced == state: counter cleared.
  - synced != state: counter increments.
  - counter == DEBOUNCE_CYCLES-1 with synced != state: state <= synced, counter <= 0.
  - Any glitch back to state before then clears the counter; no partial credit.
- select and adj are the debounced states of sw_select and sw_adj directly.
  - Latency: raw change held stable -> output changes on edge 2+DEBOUNCE_CYCLES.
- Press detection: registered rising edge of the debounced button state. Adds one cycle, so total latency is 3+DEBOUNCE_CYCLES edges.
- rst_d: high for exactly one cycle per accepted btn_reset press. A held button yields no repeat; release produces nothing.
- pause_d: on the press cycle of btn_pause, pause_d <= ~pause_d.
  - A reset press forces pause_d <= 0.
  - Same-cycle pause and reset presses: reset wins, pause_d = 0.
- Tick dividers, free-running, cleared only by rst; rst_d does not affect them:
  - c1 counts 0..CLK_HZ-1 and wraps. clk_1hz = 1 in the cycle c1 == CLK_HZ-1.
  - c2 counts 0..CLK_HZ/2-1 and wraps. clk_2hz = 1 in the cycle c2 == CLK_HZ/2-1.
  - Both counters start together, so every clk_1hz pulse coincides with a clk_2hz pulse.
  - c4 toggles clk_4hz when reaching CLK_HZ/8-1, then wraps to 0.
  - cf toggles clk_fst when reaching CLK_HZ/(2*FST_HZ)-1, then wraps to 0.
  - All tick outputs are registered; first clk_1hz pulse occurs on edge CLK_HZ after reset release.

Optional Feature:
ADJ_TICK_GATE_EN:
- Defined: clk_1hz is forced to 0 while adj == 1. Divider c1 keeps counting, so phase is preserved. When adj falls, the next pulse appears at the normal c1 wrap.
- Undefined: clk_1hz is ungated; the counter is responsible for freezing during adjust.

Test Plan:
(CLK_HZ=80, FST_HZ=20, DEBOUNCE_CYCLES=4 for all scenarios.)
1. Reset then idle 160 cycles -> clk_1hz pulses at edges 80 and 160; clk_2hz at 40, 80, 120, 160; clk_4hz toggles every 10 cycles; clk_fst toggles every 2.
2. btn_reset rises and is held 20 cycles -> rst_d high on exactly edge 7 after the rise, single cycle; no further pulse while held or on release.
3. btn_pause pressed 3 times, each held 10 cycles with 10-cycle gaps -> pause_d goes 1, 0, 1, each change 7 edges after the press.
4. sw_adj pulses high 1 cycle, low 1, high 2, low, repeated for 20 cycles -> adj stays 0; a subsequent 4-cycle-stable high sets adj on edge 6.
5. pause_d = 1, then btn_pause and btn_reset rise on the same cycle -> rst_d pulses and pause_d = 0 on that edge.
6. With ADJ_TICK_GATE_EN, adj = 1 across edge 80 -> no clk_1hz at 80 while clk_2hz still pulses. adj drops at edge 100 -> clk_1hz pulses at edge 160.
